// File: rtl/booth_mul_arbiter_if.sv
// Request/response bus of booth_mul_arbiter.
// slave: arbiter side, master: requester/consumer side.
interface booth_mul_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_mc;
    logic [NREQ*8-1:0] req_mp;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [15:0]       rsp_prod;
    logic              rsp_err;

    modport slave (
        input  req_valid, req_mc, req_mp, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err
    );

    modport master (
        output req_valid, req_mc, req_mp, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err
    );
endinterface

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: shares one 8x8 signed radix-2 Booth core among NREQ requesters.
// Round-robin grant, operand latch, start pulse, product capture on first busy-low
// cycle, tagged response over valid/ready.
// Optional feature: define BOOTH_ARB_TIMEOUT_EN for the RUN-cycle timeout and rsp_err.
module booth_mul_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = 12
) (
    input  logic                clk,
    input  logic                rst,
    booth_mul_arbiter_if.slave  bus,
    output logic                mul_start,
    output logic [7:0]          mul_mc,
    output logic [7:0]          mul_mp,
    input  logic                mul_busy,
    input  logic [15:0]         mul_prod
);
    localparam int unsigned CAND_W = ID_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_RESP} state_t;

    // Reject unsupported configurations at elaboration.
    if (NREQ < 2 || NREQ > 8 || ID_W != $clog2(NREQ) || TIMEOUT <= 9) begin : g_param_check
        $error("booth_mul_arbiter: invalid NREQ/ID_W/TIMEOUT combination");
    end

    state_t            state;
    logic [ID_W-1:0]   last_grant;
    logic              rsp_valid_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [15:0]       rsp_prod_q;

    logic [7:0]        mc_arr [NREQ];
    logic [7:0]        mp_arr [NREQ];
    logic [ID_W-1:0]   grant_id_c;
    logic              any_valid_c;
    logic [CAND_W-1:0] rr_cand;

    // Unpack the flat operand buses per requester.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign mc_arr[g] = bus.req_mc[8*g +: 8];
        assign mp_arr[g] = bus.req_mp[8*g +: 8];
    end

    // Round-robin pick: first valid requester after last_grant, wrapping.
    always_comb begin
        any_valid_c = 1'b0;
        grant_id_c  = '0;
        rr_cand     = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            rr_cand = CAND_W'(last_grant) + CAND_W'(k);
            if (rr_cand >= CAND_W'(NREQ)) begin
                rr_cand = rr_cand - CAND_W'(NREQ);
            end
            if (!any_valid_c && bus.req_valid[rr_cand[ID_W-1:0]]) begin
                any_valid_c = 1'b1;
                grant_id_c  = rr_cand[ID_W-1:0];
            end
        end
    end

    // Grant is combinational and only offered while idle.
    assign bus.req_ready = (state == S_IDLE) ? (NREQ'(any_valid_c) << grant_id_c) : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_prod  = rsp_prod_q;

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] run_cnt;
    logic             rsp_err_q;
    logic             timeout_c;

    // Last allowed RUN cycle reached.
    assign timeout_c   = (run_cnt == CNT_W'(TIMEOUT - 1));
    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            last_grant  <= ID_W'(NREQ - 1);
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_prod_q  <= '0;
            mul_start   <= 1'b0;
            mul_mc      <= '0;
            mul_mp      <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
            run_cnt     <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            mul_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_valid_c) begin
                        mul_mc     <= mc_arr[grant_id_c];
                        mul_mp     <= mp_arr[grant_id_c];
                        rsp_id_q   <= grant_id_c;
                        last_grant <= grant_id_c;
                        mul_start  <= 1'b1;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    // Busy still shows the previous op's count here; ignore it.
`ifdef BOOTH_ARB_TIMEOUT_EN
                    run_cnt <= '0;
`endif
                    state <= S_RUN;
                end
                S_RUN: begin
                    // The core keeps counting, so only the first busy-low cycle is valid.
                    if (!mul_busy) begin
                        rsp_prod_q  <= mul_prod;
                        rsp_valid_q <= 1'b1;
                        state       <= S_RESP;
                    end
`ifdef BOOTH_ARB_TIMEOUT_EN
                    else if (timeout_c) begin
                        rsp_prod_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        run_cnt <= run_cnt + CNT_W'(1);
                    end
`endif
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
`ifdef BOOTH_ARB_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
